// File: rtl/carry_chain_sequencer.sv
// Multi-cycle add/subtract sequencer: one SLICE_W-bit ripple chain
// reused across NUM_SLICES slices, LSB slice first, carry registered.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   in_valid/ready  : request handshake; in_op, in_a, in_b, in_cin
//   out_valid/ready : result handshake; out_sum, out_cout, out_ovf,
//                     out_zero
//   busy            : high while slices are being stepped
module carry_chain_sequencer #(
    parameter int SLICE_W    = 8,
    parameter int NUM_SLICES = 4,
    localparam int TW        = SLICE_W * NUM_SLICES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [TW-1:0] in_a,
    input  logic [TW-1:0] in_b,
    input  logic          in_cin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_sum,
    output logic          out_cout,
    output logic          out_ovf,
    output logic          out_zero,
    output logic          busy
);

    localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [TW-1:0] a_q, a_d;
    logic [TW-1:0] b_q, b_d;
    logic [TW-1:0] sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               sl_cout;
    logic               accept;

    // Handshake: DONE forwards out_ready so a new op can enter
    // in the same cycle the previous result leaves.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  in_ready = 1'b0;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Operand slice mux (constant indices only)
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (idx_q == IW'(k)) begin
                a_sl = a_q[k*SLICE_W +: SLICE_W];
                b_sl = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    // One slice of ARITH-mode cells
    always_comb begin
        logic c;
        logic p;
        logic g;
        c    = carry_q;
        s_sl = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            p       = a_sl[i] ^ b_sl[i];
            g       = a_sl[i] & b_sl[i];
            s_sl[i] = p ^ c;
            c       = p ? c : g;
        end
        sl_cout = c;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                for (int k = 0; k < NUM_SLICES; k++) begin
                    if (idx_q == IW'(k))
                        sum_d[k*SLICE_W +: SLICE_W] = s_sl;
                end
                carry_d = sl_cout;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    cout_d  = sl_cout;
                    ovf_d   = (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) &&
                              (s_sl[SLICE_W-1] != a_sl[SLICE_W-1]);
                    zero_d  = (sum_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // in_op[0] selects subtract; in_op[1] selects external carry
        if (accept) begin
            state_d = ST_RUN;
            idx_d   = '0;
            a_d     = in_a;
            b_d     = in_op[0] ? ~in_b : in_b;
            carry_d = in_op[1] ? in_cin : in_op[0];
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            zero_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Self-checking bench for carry_chain_sequencer: directed cases,
// backpressure, reset mid-op and randomized back-to-back traffic.
module tb_carry_chain_sequencer;

    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = 4;
    localparam int TW         = SLICE_W * NUM_SLICES;
    localparam int N_RAND     = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [TW-1:0] in_a;
    logic [TW-1:0] in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          out_zero;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    carry_chain_sequencer #(
        .SLICE_W(SLICE_W),
        .NUM_SLICES(NUM_SLICES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_a(in_a),
        .in_b(in_b),
        .in_cin(in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_cout(out_cout),
        .out_ovf(out_ovf),
        .out_zero(out_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: {cout, ovf, zero, sum} from plain wide arithmetic
    function automatic logic [TW+2:0] model(
        input logic [1:0] op, input logic [TW-1:0] a,
        input logic [TW-1:0] b, input logic cin);
        logic [TW-1:0] bp;
        logic          c0;
        logic [TW:0]   full;
        logic          ov;
        bp = (op == 2'd1 || op == 2'd3) ? ~b : b;
        case (op)
            2'd0: c0 = 1'b0;
            2'd1: c0 = 1'b1;
            default: c0 = cin;
        endcase
        full = {1'b0, a} + {1'b0, bp} + {{TW{1'b0}}, c0};
        ov = (a[TW-1] == bp[TW-1]) && (full[TW-1] != a[TW-1]);
        return {full[TW], ov, (full[TW-1:0] == '0), full[TW-1:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(
        input logic [1:0] op, input logic [TW-1:0] a,
        input logic [TW-1:0] b, input logic cin,
        output logic [TW+2:0] res, output int lat);
        int n;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            cyc();
            n++;
        end
        cyc();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        lat = 0;
        while (!out_valid && lat < 50) begin
            cyc();
            lat++;
        end
        res = {out_cout, out_ovf, out_zero, out_sum};
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_op = 2'd0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if ({out_cout, out_ovf, out_zero, out_sum} !== '0) begin
            failures++;
            $display("FAIL reset_data: got sum=%h c=%b o=%b z=%b want 0",
                     out_sum, out_cout, out_ovf, out_zero);
        end
    endtask

    task automatic test_directed();
        logic [1:0]    ops [6];
        logic [TW-1:0] as  [6];
        logic [TW-1:0] bs  [6];
        logic          cs  [6];
        logic [TW+2:0] ex  [6];
        logic [TW+2:0] res;
        int lat;
        ops[0]=2'd0; as[0]=32'h0000_00FF; bs[0]=32'h1; cs[0]=1'b1;
        ex[0]={3'b000, 32'h0000_0100};
        ops[1]=2'd0; as[1]=32'hFFFF_FFFF; bs[1]=32'h1; cs[1]=1'b0;
        ex[1]={3'b101, 32'h0};
        ops[2]=2'd1; as[2]=32'h8000_0000; bs[2]=32'h1; cs[2]=1'b0;
        ex[2]={3'b110, 32'h7FFF_FFFF};
        ops[3]=2'd2; as[3]=32'h1; bs[3]=32'h1; cs[3]=1'b1;
        ex[3]={3'b000, 32'h3};
        ops[4]=2'd3; as[4]=32'h5; bs[4]=32'h7; cs[4]=1'b1;
        ex[4]={3'b000, 32'hFFFF_FFFE};
        ops[5]=2'd1; as[5]=32'h1234_5678; bs[5]=32'h1234_5678; cs[5]=1'b0;
        ex[5]={3'b101, 32'h0};
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], cs[i], res, lat);
            checks++;
            if (lat !== NUM_SLICES) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d want %0d",
                         i, lat, NUM_SLICES);
            end
            checks++;
            if (res !== ex[i]) begin
                failures++;
                $display("FAIL dir%0d_result: got %h want %h", i, res, ex[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [TW+2:0] res;
        logic [TW+2:0] ex2;
        int lat;
        run_op(2'd0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, res, lat);
        in_op = 2'd1;
        in_a = 32'h0000_0010;
        in_b = 32'h0000_0003;
        in_cin = 1'b0;
        in_valid = 1'b1;
        ex2 = model(2'd1, 32'h10, 32'h3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0 ||
                out_sum !== 32'h0001_0000) begin
                failures++;
                $display("FAIL bp_hold%0d: rdy=%b vld=%b busy=%b sum=%h want 0 1 0 00010000",
                         i, in_ready, out_valid, busy, out_sum);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_handoff_ready: got %b want 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_handoff_state: busy=%b vld=%b want 1 0",
                     busy, out_valid);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            cyc();
            lat++;
        end
        checks++;
        if (lat !== NUM_SLICES ||
            {out_cout, out_ovf, out_zero, out_sum} !== ex2) begin
            failures++;
            $display("FAIL bp_second: lat=%0d res=%h want lat=%0d res=%h",
                     lat, {out_cout, out_ovf, out_zero, out_sum},
                     NUM_SLICES, ex2);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [TW+2:0] res;
        int lat;
        in_op = 2'd0;
        in_a = 32'hFFFF_FFFF;
        in_b = 32'hFFFF_FFFF;
        in_cin = 1'b0;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_sum !== '0 || out_cout !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: rdy=%b vld=%b busy=%b sum=%h c=%b want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_sum, out_cout);
        end
        run_op(2'd0, 32'h2, 32'h3, 1'b1, res, lat);
        checks++;
        if (lat !== NUM_SLICES || res !== {3'b000, 32'h5}) begin
            failures++;
            $display("FAIL rst_fresh: lat=%0d res=%h want lat=%0d res=%h",
                     lat, res, NUM_SLICES, {3'b000, 32'h5});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [TW+2:0] exq[$];
        logic [TW+2:0] got;
        int sent = 0;
        int recv = 0;
        int cycles = 0;
        bit acc;
        in_valid = 1'b0;
        while (recv < N_RAND && cycles < 80000) begin
            if (!in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                in_op = 2'($urandom_range(0, 3));
                in_a = $urandom;
                in_b = $urandom;
                in_cin = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) in_b = in_a;
                if ($urandom_range(0, 7) == 0) in_a = '1;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                got = {out_cout, out_ovf, out_zero, out_sum};
                checks++;
                if (exq.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious: got %h with no request", got);
                end else begin
                    if (got !== exq[0]) begin
                        failures++;
                        $display("FAIL rand_op%0d: got %h want %h",
                                 recv, got, exq[0]);
                    end
                    void'(exq.pop_front());
                end
                recv++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exq.push_back(model(in_op, in_a, in_b, in_cin));
                sent++;
            end
            cyc();
            cycles++;
            if (acc) begin
                in_valid = 1'b0;
                in_a = $urandom;
                in_b = $urandom;
            end
        end
        out_ready = 1'b0;
        checks++;
        if (recv !== N_RAND || exq.size() !== 0) begin
            failures++;
            $display("FAIL rand_count: recv=%0d pending=%0d want %0d 0",
                     recv, exq.size(), N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
